alu_operand_fetch: RTL and testbench

//  Operand-fetch stage directly upstream of the ALU. Holds the 8x16 register file, reads Rn/Rm
//  one per cycle into A/B latches, and applies the shifter and asel/bsel muxes to B.

---
 rtl/alu_operand_fetch_if.sv | 36 +++
 rtl/alu_operand_fetch.sv | 109 ++++++++++
 tb/tb_alu_operand_fetch.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_fetch_if.sv
// Request, write-back and ALU-operand bundle for the operand-fetch stage.
// The slave modport is the fetch stage; the master modport is its upstream/ALU environment.
interface alu_operand_fetch_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_rn;
   logic [ADDR_W-1:0] req_rm;
   logic [1:0]        req_shift;
   logic [1:0]        req_aluop;
   logic              req_asel;
   logic              req_bsel;
   logic [DATA_W-1:0] req_imm;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [DATA_W-1:0] Ain;
   logic [DATA_W-1:0] Bin;
   logic [1:0]        ALUop;
   logic              op_valid;
   logic              op_ready;

   modport slave (
      input  req_valid, req_rn, req_rm, req_shift, req_aluop, req_asel, req_bsel, req_imm,
      input  wb_en, wb_addr, wb_data, op_ready,
      output req_ready, Ain, Bin, ALUop, op_valid
   );

   modport master (
      output req_valid, req_rn, req_rm, req_shift, req_aluop, req_asel, req_bsel, req_imm,
      output wb_en, wb_addr, wb_data, op_ready,
      input  req_ready, Ain, Bin, ALUop, op_valid
   );
endinterface

// File: rtl/alu_operand_fetch.sv
// ALU operand-fetch stage: 8x16 register file, sequential Rn/Rm reads, shifter and asel/bsel muxes.
// Define OPFETCH_BYPASS_EN to forward same-cycle write-back data into register reads.
module alu_operand_fetch #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8,
   parameter int ADDR_W = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_operand_fetch_if.slave   bus
);
   typedef enum logic [1:0] {S_IDLE, S_READ_A, S_READ_B, S_PRESENT} state_t;

   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_rf [NREGS];
   logic [ADDR_W-1:0] r_rn, r_rm;
   logic [1:0]        r_shift, r_aluop, r_aluop_o;
   logic              r_asel, r_bsel;
   logic [DATA_W-1:0] r_imm, r_a, r_ain, r_bin;
   logic [DATA_W-1:0] w_rd_a, w_rd_b, w_shb, w_ain, w_bin;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (bus.req_valid) w_next = S_READ_A;
         S_READ_A:  w_next = S_READ_B;
         S_READ_B:  w_next = S_PRESENT;
         S_PRESENT: if (bus.op_ready) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   assign bus.req_ready = (r_state == S_IDLE);
   assign bus.op_valid  = (r_state == S_PRESENT);
   assign bus.Ain       = r_ain;
   assign bus.Bin       = r_bin;
   assign bus.ALUop     = r_aluop_o;

   // Write-back lands regardless of FSM state; reads only see it when forwarding is built in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      end else if (bus.wb_en) begin
         r_rf[bus.wb_addr] <= bus.wb_data;
      end
   end

`ifdef OPFETCH_BYPASS_EN
   assign w_rd_a = (bus.wb_en && bus.wb_addr == r_rn) ? bus.wb_data : r_rf[r_rn];
   assign w_rd_b = (bus.wb_en && bus.wb_addr == r_rm) ? bus.wb_data : r_rf[r_rm];
`else
   assign w_rd_a = r_rf[r_rn];
   assign w_rd_b = r_rf[r_rm];
`endif

   always_comb begin
      w_shb = w_rd_b;
      case (r_shift)
         2'b01:   w_shb = {w_rd_b[DATA_W-2:0], 1'b0};
         2'b10:   w_shb = {1'b0, w_rd_b[DATA_W-1:1]};
         2'b11:   w_shb = {w_rd_b[DATA_W-1], w_rd_b[DATA_W-1:1]};
         default: w_shb = w_rd_b;
      endcase
   end

   assign w_ain = r_asel ? '0 : r_a;
   assign w_bin = r_bsel ? r_imm : w_shb;

   // The B value is consumed straight off the read port into Bin, so r_bin doubles as the B latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rn      <= '0;
         r_rm      <= '0;
         r_shift   <= '0;
         r_aluop   <= '0;
         r_asel    <= 1'b0;
         r_bsel    <= 1'b0;
         r_imm     <= '0;
         r_a       <= '0;
         r_ain     <= '0;
         r_bin     <= '0;
         r_aluop_o <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.req_valid) begin
               r_rn    <= bus.req_rn;
               r_rm    <= bus.req_rm;
               r_shift <= bus.req_shift;
               r_aluop <= bus.req_aluop;
               r_asel  <= bus.req_asel;
               r_bsel  <= bus.req_bsel;
               r_imm   <= bus.req_imm;
            end
            S_READ_A: r_a <= w_rd_a;
            S_READ_B: begin
               r_ain     <= w_ain;
               r_bin     <= w_bin;
               r_aluop_o <= r_aluop;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_operand_fetch.sv
// Randomized self-checking bench for alu_operand_fetch against a register-file/operation model.
module tb_alu_operand_fetch;
`ifdef OPFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk, reset;
   logic [15:0] m_rf [8];
   int n_chk, n_fail;

   alu_operand_fetch_if #(.DATA_W(16), .ADDR_W(3)) bus ();
   alu_operand_fetch #(.DATA_W(16), .NREGS(8), .ADDR_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] shf(input logic [15:0] b, input logic [1:0] sh);
      case (sh)
         2'd1:    return b << 1;
         2'd2:    return b >> 1;
         2'd3:    return 16'($signed(b) >>> 1);
         default: return b;
      endcase
   endfunction

   // One clock: the model sees the write-back sampled at this edge.
   task automatic step();
      @(posedge clk);
      if (bus.wb_en) m_rf[bus.wb_addr] = bus.wb_data;
      #1;
   endtask

   task automatic rnd_wb(input bit en);
      bus.wb_en   = en ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.wb_addr = 3'($urandom_range(0, 7));
      bus.wb_data = 16'($urandom);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
      step();
      bus.wb_en = 1'b0;
   endtask

   function automatic logic [15:0] rd(input logic [2:0] a);
      if (BYP && bus.wb_en && bus.wb_addr == a) return bus.wb_data;
      return m_rf[a];
   endfunction

   task automatic do_op(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh,
                        input logic [1:0] op, input bit asel, input bit bsel, input logic [15:0] imm,
                        input bit f_en, input logic [2:0] f_addr, input logic [15:0] f_data,
                        input bit rw, input int hold);
      logic [15:0] ea, eb;
      check("idle_req_ready", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1; bus.req_rn = rn; bus.req_rm = rm; bus.req_shift = sh;
      bus.req_aluop = op; bus.req_asel = asel; bus.req_bsel = bsel; bus.req_imm = imm;
      rnd_wb(rw);
      step();
      // Request fields after acceptance are junk and must be ignored.
      bus.req_valid = 1'b0; bus.req_rn = 3'($urandom); bus.req_rm = 3'($urandom);
      bus.req_imm = 16'($urandom); bus.req_shift = 2'($urandom); bus.req_asel = 1'($urandom);
      bus.op_ready = 1'($urandom_range(0, 1));
      check("reada_req_ready", 32'(bus.req_ready), 32'd0);
      check("reada_op_valid", 32'(bus.op_valid), 32'd0);
      if (f_en) begin
         bus.wb_en = 1'b1; bus.wb_addr = f_addr; bus.wb_data = f_data;
      end else rnd_wb(rw);
      ea = asel ? 16'h0 : rd(rn);
      step();
      check("readb_op_valid", 32'(bus.op_valid), 32'd0);
      rnd_wb(rw);
      eb = bsel ? imm : shf(rd(rm), sh);
      step();
      bus.op_ready = 1'b0;
      check("present_op_valid", 32'(bus.op_valid), 32'd1);
      check("present_Ain", 32'(bus.Ain), 32'(ea));
      check("present_Bin", 32'(bus.Bin), 32'(eb));
      check("present_ALUop", 32'(bus.ALUop), 32'(op));
      for (int i = 0; i < hold; i++) begin
         rnd_wb(rw);
         step();
         check("hold_op_valid", 32'(bus.op_valid), 32'd1);
         check("hold_req_ready", 32'(bus.req_ready), 32'd0);
         check("hold_Ain", 32'(bus.Ain), 32'(ea));
         check("hold_Bin", 32'(bus.Bin), 32'(eb));
         check("hold_ALUop", 32'(bus.ALUop), 32'(op));
      end
      bus.op_ready = 1'b1;
      rnd_wb(rw);
      step();
      bus.op_ready = 1'b0;
      bus.wb_en = 1'b0;
      check("done_op_valid", 32'(bus.op_valid), 32'd0);
      check("done_req_ready", 32'(bus.req_ready), 32'd1);
      check("done_Ain_kept", 32'(bus.Ain), 32'(ea));
      check("done_Bin_kept", 32'(bus.Bin), 32'(eb));
   endtask

   task automatic read_all();
      for (int i = 0; i < 8; i++)
         do_op(3'(i), 3'(i), 2'd0, 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 0);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
      bus.req_valid = 0; bus.req_rn = 0; bus.req_rm = 0; bus.req_shift = 0; bus.req_aluop = 0;
      bus.req_asel = 0; bus.req_bsel = 0; bus.req_imm = 0; bus.wb_en = 0; bus.wb_addr = 0;
      bus.wb_data = 0; bus.op_ready = 0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // 1: reset state and empty register file
      check("rst_Ain", 32'(bus.Ain), 32'd0);
      check("rst_Bin", 32'(bus.Bin), 32'd0);
      check("rst_ALUop", 32'(bus.ALUop), 32'd0);
      check("rst_op_valid", 32'(bus.op_valid), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      read_all();

      // 2: basic operation
      wr(3'd2, 16'd7); wr(3'd5, 16'd2);
      do_op(3'd2, 3'd5, 2'd0, 2'd1, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 0);
      check("t2_Ain", 32'(bus.Ain), 32'd7);
      check("t2_Bin", 32'(bus.Bin), 32'd2);
      check("t2_ALUop", 32'(bus.ALUop), 32'd1);

      // 3: shifter
      wr(3'd1, 16'h8004);
      do_op(3'd0, 3'd1, 2'd1, 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 0);
      check("t3_lsl", 32'(bus.Bin), 32'h0008);
      do_op(3'd0, 3'd1, 2'd2, 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 0);
      check("t3_lsr", 32'(bus.Bin), 32'h4002);
      do_op(3'd0, 3'd1, 2'd3, 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 0);
      check("t3_asr", 32'(bus.Bin), 32'hC002);

      // 4: asel/bsel with back-pressure
      do_op(3'd2, 3'd5, 2'd1, 2'd3, 1'b1, 1'b1, 16'hFFF7, 1'b0, 3'd0, 16'h0, 1'b0, 5);
      check("t4_Ain", 32'(bus.Ain), 32'd0);
      check("t4_Bin", 32'(bus.Bin), 32'hFFF7);

      // 5: write-back colliding with the Rn read
      wr(3'd3, 16'd4);
      do_op(3'd3, 3'd0, 2'd0, 2'd2, 1'b0, 1'b0, 16'h0, 1'b1, 3'd3, 16'd9, 1'b0, 0);
      check("t5_Ain_collide", 32'(bus.Ain), BYP ? 32'd9 : 32'd4);
      do_op(3'd3, 3'd3, 2'd0, 2'd2, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 0);
      check("t5_Ain_later", 32'(bus.Ain), 32'd9);

      // 6: reset during READ_B
      bus.req_valid = 1'b1; bus.req_rn = 3'd3; bus.req_rm = 3'd2; bus.req_aluop = 2'd3;
      bus.req_asel = 1'b0; bus.req_bsel = 1'b0; bus.req_shift = 2'd0;
      step();
      bus.req_valid = 1'b0;
      step();
      #2 reset = 1'b1;
      #1;
      check("t6_op_valid", 32'(bus.op_valid), 32'd0);
      check("t6_req_ready", 32'(bus.req_ready), 32'd1);
      check("t6_Ain", 32'(bus.Ain), 32'd0);
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
      @(posedge clk);
      #1 reset = 1'b0;
      check("t6_op_valid_after", 32'(bus.op_valid), 32'd0);
      read_all();
      wr(3'd6, 16'h1234);
      do_op(3'd6, 3'd6, 2'd2, 2'd1, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1);
      check("t6_next_Ain", 32'(bus.Ain), 32'h1234);
      check("t6_next_Bin", 32'(bus.Bin), 32'h091A);

      // Randomized operations with background write-back traffic
      for (int n = 0; n < 40; n++) begin
         bit fe;
         logic [2:0] rn;
         rn = 3'($urandom);
         fe = 1'($urandom_range(0, 3) == 0);
         do_op(rn, 3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
               16'($urandom), fe, rn, 16'($urandom), 1'b1, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
